// File: rtl/pipe_rx_frame_decoder_pkg.sv
// pipe_rx_frame_decoder_pkg: header layout, parser states and shared defaults
package pipe_rx_frame_decoder_pkg;
  localparam int CHAN_LSB = 12;
  localparam int CHAN_W = 4;
  localparam int ADDR_LSB = 4;
  localparam int ADDR_W = 8;
  localparam int N_LSB = 2;
  localparam int N_W = 2;
  localparam int UPD_BIT = 1;
  localparam int DATA_W = 48;
  localparam int ERR_W = 8;
  localparam int DEFAULT_TIMEOUT = 1024;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, EMIT = 2'd2} state_t;
endpackage

// File: rtl/pipe_rx_frame_decoder_if.sv
// pipe_rx_frame_decoder_if: host pipe-in, parameter output and status bundle
interface pipe_rx_frame_decoder_if #(parameter int W_EP = 16);
  logic pipe_write_in;
  logic [W_EP-1:0] pipe_data_in;
  logic pipe_ready_out;
  logic param_valid_out;
  logic param_ready_in;
  logic [3:0] param_chan_out;
  logic [7:0] param_addr_out;
  logic [47:0] param_data_out;
  logic module_update_out;
  logic overflow_out;
  logic [7:0] err_count_out;
  logic clear_err_in;
  modport master (
    output pipe_write_in, pipe_data_in, param_ready_in, clear_err_in,
    input pipe_ready_out, param_valid_out, param_chan_out, param_addr_out,
    input param_data_out, module_update_out, overflow_out, err_count_out
  );
  modport slave (
    input pipe_write_in, pipe_data_in, param_ready_in, clear_err_in,
    output pipe_ready_out, param_valid_out, param_chan_out, param_addr_out,
    output param_data_out, module_update_out, overflow_out, err_count_out
  );
endinterface

// File: rtl/pipe_rx_frame_decoder_fifo.sv
// sync_word_fifo: single-clock word FIFO, first-word-fall-through read port
module sync_word_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_wr, do_rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  // storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/pipe_rx_frame_decoder.sv
// pipe_rx_frame_decoder: buffers host pipe words and parses them into parameter writes
module pipe_rx_frame_decoder
  import pipe_rx_frame_decoder_pkg::*;
#(
  parameter int W_EP = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic clk_in,
  input logic rst_n_in,
  pipe_rx_frame_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [W_EP-1:0] word;
  logic full, empty, pop, tmo_hit, err_ev, upd;
  logic [N_W-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [DATA_W-1:0] acc;
  logic [CHAN_W-1:0] chan;
  logic [ADDR_W-1:0] addr;
  logic param_valid, module_update, overflow;
  logic [ERR_W-1:0] err_count;
  assign pop = !empty && state != EMIT;
  assign tmo_hit = state == DATA && empty && tmo == TW'(TIMEOUT - 1);
  assign err_ev = (state == IDLE && !empty && word[N_LSB +: N_W] == '0) || tmo_hit;
  sync_word_fifo #(.W(W_EP), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_in),
    .rst_n(rst_n_in),
    .wr_en(bus.pipe_write_in),
    .wr_data(bus.pipe_data_in),
    .rd_en(pop),
    .rd_data(word),
    .full(full),
    .empty(empty)
  );
  // frame parser: header -> data words -> hold result until accepted
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      chan <= '0;
      addr <= '0;
      upd <= 1'b0;
      acc <= '0;
      cnt <= '0;
      tmo <= '0;
      param_valid <= 1'b0;
      module_update <= 1'b0;
    end else begin
      module_update <= 1'b0;
      case (state)
        IDLE:
          if (!empty && word[N_LSB +: N_W] != '0) begin
            chan <= word[CHAN_LSB +: CHAN_W];
            addr <= word[ADDR_LSB +: ADDR_W];
            upd <= word[UPD_BIT];
            acc <= '0;
            cnt <= word[N_LSB +: N_W];
            tmo <= '0;
            state <= DATA;
          end
        DATA:
          if (!empty) begin
            acc <= {acc[DATA_W-W_EP-1:0], word};
            cnt <= cnt - 1'b1;
            tmo <= '0;
            if (cnt == N_W'(1)) begin
              state <= EMIT;
              param_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            tmo <= '0;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        EMIT:
          if (bus.param_ready_in) begin
            param_valid <= 1'b0;
            module_update <= upd;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  // error counter saturates; a coinciding error beats a clear
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      err_count <= '0;
      overflow <= 1'b0;
    end else begin
      err_count <= err_ev ? (bus.clear_err_in ? ERR_W'(1) : (&err_count ? err_count : err_count + 1'b1))
                          : (bus.clear_err_in ? '0 : err_count);
      overflow <= (bus.pipe_write_in && full) || (overflow && !bus.clear_err_in);
    end
  assign bus.pipe_ready_out = !full;
  assign bus.param_valid_out = param_valid;
  assign bus.param_chan_out = chan;
  assign bus.param_addr_out = addr;
  assign bus.param_data_out = acc;
  assign bus.module_update_out = module_update;
  assign bus.overflow_out = overflow;
  assign bus.err_count_out = err_count;
endmodule

// File: tb/tb_pipe_rx_frame_decoder.sv
// tb_pipe_rx_frame_decoder: directed frames checked against a queue-based reference model
module tb_pipe_rx_frame_decoder;
  localparam int DEPTH = 16;
  localparam int TMO = 1024;
  logic clk = 1'b0;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 0;
  always #5 clk = ~clk;
  pipe_rx_frame_decoder_if #(.W_EP(16)) b ();
  pipe_rx_frame_decoder #(.W_EP(16), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(b)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic [15:0] mq[$];
  logic [15:0] mw[$];
  logic [15:0] m_hdr, w;
  logic [47:0] m_data;
  logic [7:0] m_err;
  bit m_inf, m_emit, m_upd, m_ovf, full_pre, ev;
  int m_need, m_idle;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mw.delete();
      m_inf = 0; m_emit = 0; m_upd = 0; m_ovf = 0; m_err = 0;
      m_idle = 0; m_need = 0; m_hdr = 0; m_data = 0;
    end else begin
      full_pre = mq.size() == DEPTH;
      ev = 0;
      m_upd = 0;
      if (m_emit) begin
        if (b.param_ready_in) begin
          m_emit = 0;
          m_upd = m_hdr[1];
        end
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        if (!m_inf) begin
          if (w[3:2] == 2'd0) ev = 1;
          else begin
            m_inf = 1; m_need = int'(w[3:2]); m_hdr = w; mw.delete(); m_idle = 0;
          end
        end else begin
          mw.push_back(w);
          m_idle = 0;
          if (mw.size() == m_need) begin
            m_inf = 0; m_emit = 1; m_data = 0;
            foreach (mw[i]) m_data += 48'(mw[i]) << (16 * (m_need - 1 - i));
          end
        end
      end else if (m_inf) begin
        m_idle++;
        if (m_idle == TMO) begin
          ev = 1; m_inf = 0;
        end
      end
      if (b.pipe_write_in && !full_pre) mq.push_back(b.pipe_data_in);
      m_ovf = (b.pipe_write_in && full_pre) || (m_ovf && !b.clear_err_in);
      if (ev) m_err = b.clear_err_in ? 8'd1 : (m_err == 8'd255 ? m_err : m_err + 8'd1);
      else if (b.clear_err_in) m_err = 0;
    end
  end
  always @(negedge clk) if (cmp_en) begin
    chk("pipe_ready", b.pipe_ready_out, mq.size() != DEPTH);
    chk("param_valid", b.param_valid_out, m_emit);
    chk("module_update", b.module_update_out, m_upd);
    chk("overflow", b.overflow_out, m_ovf);
    chk("err_count", b.err_count_out, m_err);
    if (m_emit) begin
      chk("chan", b.param_chan_out, m_hdr[15:12]);
      chk("addr", b.param_addr_out, m_hdr[11:4]);
      chk("data", b.param_data_out, m_data);
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr_word(input logic [15:0] d);
    b.pipe_write_in = 1'b1;
    b.pipe_data_in = d;
    tick(1);
    b.pipe_write_in = 1'b0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!b.param_valid_out && cyc < 20) begin
      tick(1);
      cyc++;
    end
    if (!b.param_valid_out) chk("valid_timeout", 0, 1);
  endtask
  task automatic accept();
    b.param_ready_in = 1'b1;
    tick(1);
    b.param_ready_in = 1'b0;
  endtask
  task automatic chk_param(input string tag, input logic [3:0] c, input logic [7:0] a, input logic [47:0] d);
    chk({tag, "_chan"}, b.param_chan_out, c);
    chk({tag, "_addr"}, b.param_addr_out, a);
    chk({tag, "_data"}, b.param_data_out, d);
  endtask
  int cyc;
  initial begin
    b.pipe_write_in = 1'b0;
    b.pipe_data_in = '0;
    b.param_ready_in = 1'b0;
    b.clear_err_in = 1'b0;
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    cmp_en = 1;
    tick(1);
    chk("rst_ready", b.pipe_ready_out, 1);
    chk("rst_valid", b.param_valid_out, 0);
    chk("rst_err", b.err_count_out, 0);
    chk("rst_ovf", b.overflow_out, 0);
    // single-word frame
    wr_word(16'h1234);
    wr_word(16'hABCD);
    wait_valid(cyc);
    chk("lat_1word", cyc, 1);
    chk_param("f1", 4'h1, 8'h23, 48'h0000_0000_ABCD);
    accept();
    chk("f1_noupd", b.module_update_out, 0);
    chk("f1_released", b.param_valid_out, 0);
    // three-word frame with update request
    wr_word(16'h456E);
    wr_word(16'h0001);
    wr_word(16'h0002);
    wr_word(16'h0003);
    wait_valid(cyc);
    chk_param("f3", 4'h4, 8'h56, 48'h0001_0002_0003);
    accept();
    chk("f3_upd", b.module_update_out, 1);
    tick(1);
    chk("f3_upd_pulse", b.module_update_out, 0);
    // zero-length header is an error, next frame still decodes
    wr_word(16'h7770);
    wr_word(16'h9AB4);
    wr_word(16'h5A5A);
    wait_valid(cyc);
    chk("n0_err", b.err_count_out, 1);
    chk_param("n0", 4'h9, 8'hAB, 48'h5A5A);
    accept();
    // mid-frame timeout fires after exactly TMO idle cycles
    wr_word(16'h0008);
    tick(TMO);
    chk("tmo_before", b.err_count_out, 1);
    tick(1);
    chk("tmo_err", b.err_count_out, 2);
    wr_word(16'h3C14);
    wr_word(16'hBEEF);
    wait_valid(cyc);
    chk_param("tmo_next", 4'h3, 8'hC1, 48'hBEEF);
    accept();
    // back-pressure: stalled output, FIFO fills and overflows
    wr_word(16'h5554);
    wr_word(16'h1111);
    for (int i = 0; i < 18; i++) wr_word(16'h0000);
    chk("full_ready", b.pipe_ready_out, 0);
    chk("full_ovf", b.overflow_out, 1);
    chk_param("stall", 4'h5, 8'h55, 48'h1111);
    accept();
    tick(20);
    chk("drain_err", b.err_count_out, 18);
    chk("drain_ovf", b.overflow_out, 1);
    b.clear_err_in = 1'b1;
    tick(1);
    b.clear_err_in = 1'b0;
    chk("clr_err", b.err_count_out, 0);
    chk("clr_ovf", b.overflow_out, 0);
    // saturation, then error coinciding with clear
    for (int i = 0; i < 260; i++) wr_word(16'h0000);
    tick(3);
    chk("sat_err", b.err_count_out, 255);
    wr_word(16'h0000);
    b.clear_err_in = 1'b1;
    tick(1);
    b.clear_err_in = 1'b0;
    chk("clr_vs_err", b.err_count_out, 1);
    // asynchronous reset in the middle of a frame
    wr_word(16'h456C);
    wr_word(16'h0001);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", b.param_valid_out, 0);
    chk("arst_err", b.err_count_out, 0);
    chk("arst_ready", b.pipe_ready_out, 1);
    chk_param("arst", 4'h0, 8'h00, 48'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1);
    wr_word(16'h2224);
    wr_word(16'h0042);
    wait_valid(cyc);
    chk_param("post_rst", 4'h2, 8'h22, 48'h42);
    accept();
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
